// File: rtl/vga_sync_receiver_if.sv
// Sync/pixel bundle between a VGA source and the timing receiver.
// master drives pixel tick, syncs and colour; slave returns recovered timing.
interface vga_sync_receiver_if;
  logic       i_pixel_clock;
  logic       i_hsync;
  logic       i_vsync;
  logic       i_red;
  logic       i_green;
  logic       i_blue;
  logic       o_locked;
  logic       o_display_on;
  logic [9:0] o_h_spot;
  logic [9:0] o_v_spot;
  logic [2:0] o_color;
  logic       o_frame_start;
  logic       o_error;
  logic [7:0] o_err_count;

  modport master (
    output i_pixel_clock, i_hsync, i_vsync,
    output i_red, i_green, i_blue,
    input  o_locked, o_display_on,
    input  o_h_spot, o_v_spot, o_color,
    input  o_frame_start, o_error, o_err_count
  );

  modport slave (
    input  i_pixel_clock, i_hsync, i_vsync,
    input  i_red, i_green, i_blue,
    output o_locked, o_display_on,
    output o_h_spot, o_v_spot, o_color,
    output o_frame_start, o_error, o_err_count
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers h/v position, checks timing, locks.
// Ports: i_clock, i_reset (async, active high), bus (slave modport).
module vga_sync_receiver #(
  parameter int H_ACTIVE    = 640,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  vga_sync_receiver_if.slave bus
);
  localparam logic [9:0] H_LO = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_HI = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_LO = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_HI = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0] H_END = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_END = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SW = 10'(H_SYNC - 1);
  localparam logic [9:0] V_SW = 10'(V_SYNC - 1);
  localparam logic [9:0] C_MAX = 10'd1023;
  localparam logic [9:0] C_PRE = 10'd1022;
  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t     state_q;
  logic       hs_q;
  logic       vs_q;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic [7:0] good_q;
  logic       frame_bad;
  logic       tick;
  logic       h_fall;
  logic       h_rise;
  logic       v_fall;
  logic       v_rise;
  logic       viol;
  logic       active;
  logic       disp;

  assign tick   = bus.i_pixel_clock;
  assign h_fall = tick & hs_q & ~bus.i_hsync;
  assign h_rise = tick & ~hs_q & bus.i_hsync;
  assign v_fall = tick & vs_q & ~bus.i_vsync;
  assign v_rise = tick & ~vs_q & bus.i_vsync;

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (h_fall)
      h_nxt = '0;
    else if (h_cnt != C_MAX)
      h_nxt = h_cnt + 10'd1;
    if (v_fall)
      v_nxt = '0;
    else if (h_fall && v_cnt != C_MAX)
      v_nxt = v_cnt + 10'd1;
  end

  // Saturation is flagged once, on the step into 1023.
  assign viol = tick & (
    (h_rise && h_cnt != H_SW) ||
    (h_fall && h_cnt != H_END) ||
    (v_rise && v_cnt != V_SW) ||
    (v_fall && v_cnt != V_END) ||
    (!h_fall && h_cnt == C_PRE) ||
    (h_fall && !v_fall && v_cnt == C_PRE));

  assign active = (h_nxt >= H_LO) && (h_nxt < H_HI) &&
                  (v_nxt >= V_LO) && (v_nxt < V_HI);
  assign disp = active && (state_q == LOCKED) && !viol;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q           <= SEARCH;
      hs_q              <= 1'b1;
      vs_q              <= 1'b1;
      h_cnt             <= '0;
      v_cnt             <= '0;
      good_q            <= '0;
      frame_bad         <= 1'b0;
      bus.o_locked      <= 1'b0;
      bus.o_display_on  <= 1'b0;
      bus.o_h_spot      <= '0;
      bus.o_v_spot      <= '0;
      bus.o_color       <= '0;
      bus.o_frame_start <= 1'b0;
      bus.o_error       <= 1'b0;
      bus.o_err_count   <= '0;
    end else begin
      bus.o_frame_start <= 1'b0;
      bus.o_error       <= 1'b0;
      if (tick) begin
        hs_q              <= bus.i_hsync;
        vs_q              <= bus.i_vsync;
        h_cnt             <= h_nxt;
        v_cnt             <= v_nxt;
        bus.o_frame_start <= v_fall;
        bus.o_display_on  <= disp;
        bus.o_h_spot      <= active ? h_nxt - H_LO : '0;
        bus.o_v_spot      <= active ? v_nxt - V_LO : '0;
        bus.o_color       <= disp ?
          {bus.i_red, bus.i_green, bus.i_blue} : 3'b000;
        unique case (state_q)
          SEARCH: begin
            if (v_fall) begin
              state_q   <= ACQUIRE;
              good_q    <= '0;
              frame_bad <= 1'b0;
            end
          end
          ACQUIRE: begin
            if (viol) begin
              bus.o_error <= 1'b1;
              good_q      <= '0;
              if (bus.o_err_count != 8'hFF)
                bus.o_err_count <= bus.o_err_count + 8'd1;
            end
            // A violation on the edge itself spoils the frame it closes.
            if (v_fall) begin
              frame_bad <= 1'b0;
              if (viol || frame_bad)
                good_q <= '0;
              else if (good_q + 8'd1 >= LOCK_N) begin
                state_q      <= LOCKED;
                bus.o_locked <= 1'b1;
                good_q       <= '0;
              end else
                good_q <= good_q + 8'd1;
            end else if (viol)
              frame_bad <= 1'b1;
          end
          LOCKED: begin
            if (viol) begin
              state_q      <= SEARCH;
              bus.o_locked <= 1'b0;
              bus.o_error  <= 1'b1;
              if (bus.o_err_count != 8'hFF)
                bus.o_err_count <= bus.o_err_count + 8'd1;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver using a shrunken video timing.
// Drives frames tick by tick and checks lock, pixel and error behaviour.
module tb_vga_sync_receiver;
  localparam int HA  = 8;
  localparam int HS  = 4;
  localparam int HB  = 2;
  localparam int HT  = 20;
  localparam int VA  = 4;
  localparam int VS  = 2;
  localparam int VB  = 1;
  localparam int VT  = 10;
  localparam int ALL = 100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   err_seen = 0;
  int   fs_seen = 0;
  logic lk_seen = 1'b0;
  logic lk_first = 1'b0;
  logic chk_tbl = 1'b0;

  vga_sync_receiver_if vif();

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
    .LOCK_FRAMES(2)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus(vif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         line;
    int         col;
    logic [2:0] rgb;
    logic       disp;
    int         hs;
    int         vs;
    logic [2:0] color;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input int act,
                       input int exp);
    total_cnt++;
    if (act == exp)
      pass_cnt++;
    else
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, int'(vif.o_locked), 0);
    check({tag, "_disp"}, int'(vif.o_display_on), 0);
    check({tag, "_hspot"}, int'(vif.o_h_spot), 0);
    check({tag, "_vspot"}, int'(vif.o_v_spot), 0);
    check({tag, "_color"}, int'(vif.o_color), 0);
    check({tag, "_fstart"}, int'(vif.o_frame_start), 0);
    check({tag, "_error"}, int'(vif.o_error), 0);
    check({tag, "_errcnt"}, int'(vif.o_err_count), 0);
  endtask

  task automatic tick(input logic hs, input logic vs,
                      input logic [2:0] rgb);
    @(negedge clk);
    vif.i_hsync = hs;
    vif.i_vsync = vs;
    {vif.i_red, vif.i_green, vif.i_blue} = rgb;
    vif.i_pixel_clock = 1'b1;
    @(negedge clk);
    vif.i_pixel_clock = 1'b0;
    if (vif.o_error) err_seen++;
    if (vif.o_frame_start) fs_seen++;
    if (vif.o_locked) lk_seen = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input int lines, input int bad_a,
                            input int bad_b, input int first,
                            input int last);
    for (int l = 0; l < lines; l++) begin
      for (int t = 0; t < HT; t++) begin
        int idx;
        int hw;
        int hit;
        logic [2:0] rgb;
        idx = l * HT + t;
        if (idx >= first && idx <= last) begin
          hw  = (l == bad_a || l == bad_b) ? HS - 1 : HS;
          rgb = 3'b111;
          hit = -1;
          if (chk_tbl)
            for (int k = 0; k < 9; k++)
              if (tbl[k].line == l && tbl[k].col == t) begin
                hit = k;
                rgb = tbl[k].rgb;
              end
          tick((t < hw) ? 1'b0 : 1'b1,
               (l < VS) ? 1'b0 : 1'b1, rgb);
          if (idx == 0) lk_first = vif.o_locked;
          if (hit >= 0) begin
            check($sformatf("tbl%0d_disp", hit),
                  int'(vif.o_display_on), int'(tbl[hit].disp));
            check($sformatf("tbl%0d_hspot", hit),
                  int'(vif.o_h_spot), tbl[hit].hs);
            check($sformatf("tbl%0d_vspot", hit),
                  int'(vif.o_v_spot), tbl[hit].vs);
            check($sformatf("tbl%0d_color", hit),
                  int'(vif.o_color), int'(tbl[hit].color));
          end
        end
      end
    end
  endtask

  initial begin
    tbl[0] = '{3, 6, 3'b101, 1'b1, 0, 0, 3'b101};
    tbl[1] = '{3, 5, 3'b111, 1'b0, 0, 0, 3'b000};
    tbl[2] = '{3, 13, 3'b011, 1'b1, 7, 0, 3'b011};
    tbl[3] = '{3, 14, 3'b111, 1'b0, 0, 0, 3'b000};
    tbl[4] = '{6, 6, 3'b110, 1'b1, 0, 3, 3'b110};
    tbl[5] = '{7, 6, 3'b111, 1'b0, 0, 0, 3'b000};
    tbl[6] = '{2, 6, 3'b111, 1'b0, 0, 0, 3'b000};
    tbl[7] = '{4, 10, 3'b010, 1'b1, 4, 1, 3'b010};
    tbl[8] = '{6, 13, 3'b001, 1'b1, 7, 3, 3'b001};

    vif.i_pixel_clock = 1'b0;
    vif.i_hsync = 1'b1;
    vif.i_vsync = 1'b1;
    vif.i_red = 1'b0;
    vif.i_green = 1'b0;
    vif.i_blue = 1'b0;

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // release mid-frame, then two good frames to lock
    send_frame(VT, -1, -1, 7 * HT, ALL);
    check("search_quiet", err_seen, 0);
    fs_seen = 0;
    send_frame(VT, -1, -1, 0, ALL);
    send_frame(VT, -1, -1, 0, ALL);
    check("unlocked_2nd_fall", int'(lk_first), 0);
    check("unlocked_end_f2", int'(vif.o_locked), 0);
    chk_tbl = 1'b1;
    send_frame(VT, -1, -1, 0, ALL);
    chk_tbl = 1'b0;
    check("lock_3rd_fall", int'(lk_first), 1);
    check("locked_end_f3", int'(vif.o_locked), 1);
    check("frame_starts", fs_seen, 3);
    check("no_err_lock", err_seen, 0);

    // narrow hsync while locked; second bad line lands in SEARCH
    err_seen = 0;
    send_frame(VT, 4, 6, 0, ALL);
    check("narrow_err", err_seen, 1);
    check("narrow_cnt", int'(vif.o_err_count), 1);
    check("narrow_unlock", int'(vif.o_locked), 0);

    // short frames in ACQUIRE
    err_seen = 0;
    lk_seen = 1'b0;
    repeat (4) send_frame(VT - 1, -1, -1, 0, ALL);
    send_frame(VT, -1, -1, 0, ALL);
    check("short_errs", err_seen, 4);
    check("short_nolock", int'(lk_seen), 0);
    check("short_cnt", int'(vif.o_err_count), 5);

    // hsync held low: saturation, then bad width at release
    err_seen = 0;
    repeat (1100) tick(1'b0, 1'b1, 3'b000);
    check("sat_err", err_seen, 1);
    err_seen = 0;
    tick(1'b1, 1'b1, 3'b000);
    check("wide_err", err_seen, 1);
    check("wide_cnt", int'(vif.o_err_count), 7);

    // error counter saturation
    err_seen = 0;
    repeat (160) begin
      tick(1'b0, 1'b1, 3'b000);
      tick(1'b1, 1'b1, 3'b000);
    end
    check("flood_pulses", err_seen, 320);
    check("cnt_sat", int'(vif.o_err_count), 255);

    // relock, then async reset mid-line
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset2");
    rst = 1'b0;
    send_frame(VT, -1, -1, 0, ALL);
    send_frame(VT, -1, -1, 0, ALL);
    chk_tbl = 1'b1;
    send_frame(VT, -1, -1, 0, ALL);
    check("relock1", int'(lk_first), 1);
    send_frame(VT, -1, -1, 0, 4 * HT + 8);
    chk_tbl = 1'b0;
    check("mid_disp", int'(vif.o_display_on), 1);
    check("mid_hspot", int'(vif.o_h_spot), 2);
    check("mid_vspot", int'(vif.o_v_spot), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    err_seen = 0;
    lk_seen = 1'b0;
    send_frame(VT, -1, -1, 4 * HT + 9, ALL);
    check("post_rst_quiet", err_seen, 0);
    check("post_rst_unlock", int'(lk_seen), 0);
    send_frame(VT, -1, -1, 0, ALL);
    send_frame(VT, -1, -1, 0, ALL);
    check("relock_early", int'(lk_first), 0);
    send_frame(VT, -1, -1, 0, ALL);
    check("relock2", int'(lk_first), 1);
    check("relock_quiet", err_seen, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_SYNC, default 96, hsync low width in pixel ticks; H_BACK, default 48, back porch; H_TOTAL, default 800, ticks per line.
REQ-003 Parameter V_ACTIVE, default 480, visible lines; V_SYNC, default 2, vsync low width in lines; V_BACK, default 33, back porch; V_TOTAL, default 525, lines per frame.
REQ-004 Parameter LOCK_FRAMES, default 2, consecutive good frames required to lock.
REQ-005 i_clock  input  1  100 MHz system clock; sole clock.
REQ-006 i_reset  input  1  asynchronous, active-high reset.
REQ-007 i_pixel_clock  input  1  one-cycle pixel tick enable (every 4th i_clock); all sampling occurs only on ticks.
REQ-008 i_hsync, i_vsync  input  1 each  active-low sync inputs.
REQ-009 i_red, i_green, i_blue  input  1 each  pixel color inputs.
REQ-010 o_locked  output  1  high while the timing lock is held.
REQ-011 o_display_on  output  1  high for ticks inside the active region while locked.
REQ-012 o_h_spot, o_v_spot  output  10 each  recovered pixel column/row; 0 outside the active region.
REQ-013 o_color  output  3  captured {red,green,blue}; 3'b000 when o_display_on low.
REQ-014 o_frame_start  output  1  one-cycle pulse on each vsync falling edge.
REQ-015 o_error  output  1  one-cycle pulse on any timing violation.
REQ-016 o_err_count  output  8  saturating count of violations.

Function
REQ-017 Sync edges detected by comparing each tick's sample with the previous tick's sample; no activity between ticks.
REQ-018 h_cnt (10 b) = 0 on the tick that samples an hsync falling edge, else +1 per tick; it saturates at 1023, never wraps.
REQ-019 v_cnt (10 b) = 0 on a vsync falling edge, else +1 on each hsync falling edge; it saturates at 1023.
REQ-020 Active region: H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE (144..783) and V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_ACTIVE (35..514).
REQ-021 o_h_spot = h_cnt-144, o_v_spot = v_cnt-35 inside the active region; all pixel outputs are registered and update 1 i_clock after the tick.
REQ-022 Violations: hsync low width != H_SYNC at its rising edge; h_cnt != H_TOTAL-1 on the tick before an hsync falling edge; vsync low width != V_SYNC lines; v_cnt != V_TOTAL-1 at a vsync falling edge; h_cnt or v_cnt saturating.
REQ-023 FSM states: SEARCH, ACQUIRE, LOCKED.
REQ-024 SEARCH: on the first vsync falling edge, clear good_frames and go to ACQUIRE; violations are ignored and not counted.
REQ-025 ACQUIRE: a frame with no violation increments good_frames at the next vsync falling edge; on reaching LOCK_FRAMES go to LOCKED; any violation clears good_frames and stays in ACQUIRE.
REQ-026 LOCKED: o_locked high; any violation goes to SEARCH, drops o_locked the next cycle and increments o_err_count.
REQ-027 o_error pulses on every violation in ACQUIRE or LOCKED; o_err_count holds at 255.
REQ-028 A violation coinciding with a vsync falling edge counts against the frame that ends on that edge.
REQ-029 o_frame_start pulses in all states.

Reset
REQ-030 i_reset high asynchronously forces SEARCH, counters and good_frames to 0, and every output to 0, including o_err_count.
REQ-031 Released mid-frame, the block stays in SEARCH until the next vsync falling edge; no violations are flagged before it.

Verification
REQ-032 Two standard 640x480 frames after reset -> o_locked rises 1 cycle after the third vsync falling edge; o_error never pulses.
REQ-033 Locked; pixel at column 0, row 0 with RGB=3'b101 -> o_display_on=1, o_h_spot=0, o_v_spot=0, o_color=3'b101; at h_cnt=143 -> o_display_on=0, o_color=0.
REQ-034 Locked; one hsync pulse 95 ticks wide -> a single o_error pulse, o_err_count=1, o_locked=0, state SEARCH.
REQ-035 Frames of 524 lines repeated -> o_locked stays 0; o_error pulses once per frame in ACQUIRE.
REQ-036 Hsync held low 1100 ticks -> h_cnt saturates at 1023, violation flagged; 300 forced violations -> o_err_count=255.
REQ-037 i_reset asserted mid-line while locked -> all outputs 0 in the same cycle; relock takes 2 good frames after the next vsync falling edge.
